seq_mul_fsm: RTL
================

SEQ_MUL_FSM -- requirements
Module: seq_mul_fsm

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits, legal range 2 to 32.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port a, input, N bits: unsigned multiplicand.
REQ-005 SHALL have port b, input, N bits: unsigned multiplier.
REQ-006 SHALL have port start, input, 1 bit: request pulse or level.
REQ-007 SHALL have port P, output, 2N bits, registered: product.
REQ-008 SHALL have port busy, output, 1 bit, registered: an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit, registered: one-cycle completion strobe.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-011 In IDLE with start=1 at a rising CLK edge, SHALL do all of the following on that edge: capture a into the multiplicand register, capture b into the multiplier shift register, clear the 2N-bit accumulator, load the iteration counter with N, set busy=1 and enter CALC.
REQ-012 In IDLE with start=0, SHALL hold all registers, with busy=0 and done=0.
REQ-013 Each CALC cycle SHALL do the following as one operation: if multiplier LSB=1, add the multiplicand to accumulator bits [2N-1:N] with an (N+1)-bit carry-preserving sum; shift {carry, accumulator} right by 1; shift the multiplier right by 1; decrement the counter.
REQ-014 CALC SHALL last exactly N cycles, then transition to DONE on the edge where the counter reaches 0.
REQ-015 On entry to DONE, SHALL load P with the final accumulator, set done=1 for exactly one cycle, and clear busy.
REQ-016 DONE SHALL return to IDLE unconditionally on the next edge, and done SHALL return to 0 on that edge.
REQ-017 Latency: when start is accepted at edge k, done=1 and a valid P SHALL appear after edge k+N+1.
REQ-018 Back-to-back throughput SHALL be one operation per N+2 cycles.
REQ-019 start SHALL be ignored while in CALC or DONE; it is neither queued nor does it restart the operation.
REQ-020 a and b SHALL be sampled only at the accepting edge; changes to them during CALC SHALL NOT affect the result.
REQ-021 P SHALL hold its value from DONE until the DONE of the next operation; it SHALL NOT change during CALC.
REQ-022 The result SHALL be exact for all operands: P = a*b, with no overflow and no truncation in 2N bits.
REQ-023 An operand of zero SHALL still take the full N cycles and yield P=0.
REQ-024 start held high continuously SHALL start a new operation on each IDLE visit, i.e. every N+2 cycles.
REQ-025 Unreachable state encodings SHALL recover to IDLE on the next edge, with busy=0 and done=0.

Reset
REQ-026 RST=0 SHALL immediately, without waiting for CLK, force state=IDLE, P=0, busy=0, done=0, accumulator=0, counter=0 and operand registers=0.
REQ-027 Reset asserted mid-CALC SHALL abort the operation with no done pulse, and P SHALL read 0.
REQ-028 After RST deasserts, the first rising CLK edge SHALL evaluate start normally from IDLE.

Verification
REQ-029 Basic case, N=8: a=13, b=11, one-cycle start -> busy high for 9 cycles, done pulses once 9 cycles after the accepting edge, P=143 (0x008F).
REQ-030 Maximum operands, N=8: a=255, b=255 -> P=65025 (0xFE01), no carry loss.
REQ-031 Zero operand: a=0, b=200 -> P=0, done pulses after the full latency; then a=200, b=0 -> P=0.
REQ-032 Operand change and ignored start: a=7, b=6 accepted; during CALC drive a=99, b=99 and pulse start -> P=42, exactly one done pulse, no restart.
REQ-033 Mid-operation reset: start a=100, b=3; pull RST low 4 cycles in -> P=0, busy=0, done=0 immediately; after release, a=5, b=5 -> P=25.
REQ-034 Continuous start: hold start high with a=2, b=3 -> done pulses every 10 cycles, P=6 each time, busy low for exactly one IDLE cycle between operations.

Source files
------------

// File: rtl/seq_mul_fsm.sv
// Sequential shift-add unsigned multiplier: one partial product per cycle, N cycles per operation.
// P, busy and done are registered from the current state, so they trail the state by one edge.
module seq_mul_fsm #(
    parameter int N = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             start,
    output logic [2*N-1:0]   P,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [N-1:0]     mcand_r;
    logic [N-1:0]     mplier_r;
    logic [2*N-1:0]   acc_r;
    logic [2*N-1:0]   acc_s;
    logic [N:0]       sum_s;
    logic [CW-1:0]    cnt_r;
    logic [2*N-1:0]   p_s;
    logic             busy_s;
    logic             done_s;
    logic [2*N-1:0]   p_r;
    logic             busy_r;
    logic             done_r;

    assign P    = p_r;
    assign busy = busy_r;
    assign done = done_r;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the counter reaching zero on this edge ends CALC
    always_comb begin
        state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r <= CW'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        p_s    = p_r;
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    busy_s = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            CALC: busy_s = 1'b1;
            DONE: begin
                p_s    = acc_r;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Partial-product step; the extra sum bit keeps the carry that the right shift brings down
    always_comb begin
        if (mplier_r[0]) begin
            sum_s = {1'b0, acc_r[2*N-1:N]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_r[2*N-1:N]};
        end
        acc_s = {sum_s, acc_r[N-1:1]};
    end

    // Operand, accumulator and iteration counter registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mcand_r  <= {N{1'b0}};
            mplier_r <= {N{1'b0}};
            acc_r    <= {(2*N){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r  <= a;
                        mplier_r <= b;
                        acc_r    <= {(2*N){1'b0}};
                        cnt_r    <= CW'(N);
                    end else begin
                        mcand_r  <= mcand_r;
                        mplier_r <= mplier_r;
                        acc_r    <= acc_r;
                        cnt_r    <= cnt_r;
                    end
                end
                CALC: begin
                    acc_r    <= acc_s;
                    mplier_r <= {1'b0, mplier_r[N-1:1]};
                    cnt_r    <= cnt_r - CW'(1);
                end
                default: begin
                    mcand_r  <= mcand_r;
                    mplier_r <= mplier_r;
                    acc_r    <= acc_r;
                    cnt_r    <= cnt_r;
                end
            endcase
        end
    end

    // Output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_r    <= {(2*N){1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            p_r    <= p_s;
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

endmodule
